// File: rtl/pwm_dac_pkg.sv
// Shared constants and helpers for the PWM DAC block: modulation modes,
// compare-width helper and the packed-duty slice macro.
`ifndef PWM_DAC_PKG_SV
`define PWM_DAC_PKG_SV

`define PWM_DUTY_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]

package pwm_dac_pkg;

    localparam int MODE_EDGE   = 0;
    localparam int MODE_CENTER = 1;

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`endif

// File: rtl/pwm_period_counter.sv
// Shared period counter: up ramp (edge) or up/down ramp (center), boundary flag
// and a registered period_start pulse aligned with the first PWM output of a period.
module pwm_period_counter
    import pwm_dac_pkg::*;
#(
    parameter int CNT_W          = 11,
    parameter int PERIOD         = 1024,
    parameter int CENTER_ALIGNED = 0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             boundary_o,
    output logic             first_o,
    output logic             period_start_o
);

    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    dir_e             dir_q, dir_d;
    logic             period_start_q, period_start_d;

    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (!enable_i) begin
            cnt_d = '0;
            dir_d = DIR_UP;
        end else if (CENTER_ALIGNED == MODE_CENTER) begin
            // The turning value is held for one extra cycle while the direction flips.
            if (dir_q == DIR_UP) begin
                if (cnt_q == LAST) dir_d = DIR_DOWN;
                else               cnt_d = cnt_q + 1'b1;
            end else begin
                if (cnt_q == '0) dir_d = DIR_UP;
                else             cnt_d = cnt_q - 1'b1;
            end
        end else begin
            if (cnt_q == LAST) cnt_d = '0;
            else               cnt_d = cnt_q + 1'b1;
        end
    end

    assign first_o = enable_i && (cnt_q == '0) && (dir_q == DIR_UP);

    assign boundary_o = enable_i &&
        ((CENTER_ALIGNED == MODE_EDGE) ? (cnt_q == LAST)
                                       : ((cnt_q == '0) && (dir_q == DIR_DOWN)));

    assign period_start_d = first_o;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q          <= '0;
            dir_q          <= DIR_UP;
            period_start_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            dir_q          <= dir_d;
            period_start_q <= period_start_d;
        end
    end

    assign cnt_o          = cnt_q;
    assign period_start_o = period_start_q;

endmodule

// File: rtl/pwm_dac.sv
// Multi-channel PWM DAC with double-buffered duties applied only at period boundaries.
// Latency: pwm_out is registered, one cycle behind the counter; duty_ready low while a load is pending.
module pwm_dac
    import pwm_dac_pkg::*;
#(
    parameter int CHANNELS       = 2,
    parameter int DUTY_W         = 8,
    parameter int CNT_W          = 11,
    parameter int PERIOD         = 1024,
    parameter int CENTER_ALIGNED = 0
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       enable,
    input  logic [CHANNELS*DUTY_W-1:0] duty,
    input  logic                       duty_valid,
    output logic                       duty_ready,
    output logic                       period_start,
    output logic [CHANNELS-1:0]        pwm_out
);

    localparam int CMP_W = max_w(CNT_W, DUTY_W);

    logic [CNT_W-1:0]           cnt;
    logic                       boundary;
    logic                       first_cycle;

    logic                       en_q;
    logic                       pending_q, pending_d;
    logic [CHANNELS*DUTY_W-1:0] shadow_q, shadow_d;
    logic [CHANNELS*DUTY_W-1:0] active_q, active_d;
    logic [CHANNELS-1:0]        pwm_q, pwm_d;

    logic                       accept;
    logic                       first_en;
    logic                       load;

    pwm_period_counter #(
        .CNT_W          (CNT_W),
        .PERIOD         (PERIOD),
        .CENTER_ALIGNED (CENTER_ALIGNED)
    ) u_cnt (
        .clk            (clk),
        .resetn         (resetn),
        .enable_i       (enable),
        .cnt_o          (cnt),
        .boundary_o     (boundary),
        .first_o        (first_cycle),
        .period_start_o (period_start)
    );

    assign duty_ready = !pending_q;
    assign accept     = duty_valid && !pending_q;
    assign first_en   = enable && !en_q;
    assign load       = pending_q && (boundary || first_en);

    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (accept) begin
            shadow_d  = duty;
            pending_d = 1'b1;
        end else if (load) begin
            pending_d = 1'b0;
        end
        if (load) active_d = shadow_q;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [DUTY_W-1:0] eff_duty;

        // On the first enabled cycle the pending duty is compared directly so the
        // opening period (which starts at cnt 0 that very cycle) already uses it.
        assign eff_duty = (load && first_en) ? `PWM_DUTY_SLICE(shadow_q, i, DUTY_W)
                                             : `PWM_DUTY_SLICE(active_q, i, DUTY_W);

        assign pwm_d[i] = enable && (CMP_W'(cnt) < CMP_W'(eff_duty));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            en_q      <= 1'b0;
            pending_q <= 1'b0;
            shadow_q  <= '0;
            active_q  <= '0;
            pwm_q     <= '0;
        end else begin
            en_q      <= enable;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pwm_q     <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;

endmodule

// File: tb/tb_pwm_dac.sv
// Directed bench for pwm_dac: edge instance (PERIOD=16, 2 channels) and
// center instance (PERIOD=8, 1 channel) checked against hand-computed values.
module tb_pwm_dac;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        en_e, vld_e, rdy_e, ps_e;
    logic [15:0] duty_e;
    logic [1:0]  pwm_e;
    logic        en_c, vld_c, rdy_c, ps_c;
    logic [7:0]  duty_c;
    logic [0:0]  pwm_c;

    int errors = 0;
    int checks = 0;
    int k      = 0;

    pwm_dac #(
        .CHANNELS(2), .DUTY_W(8), .CNT_W(5), .PERIOD(16), .CENTER_ALIGNED(0)
    ) u_edge (
        .clk(clk), .resetn(resetn), .enable(en_e), .duty(duty_e),
        .duty_valid(vld_e), .duty_ready(rdy_e), .period_start(ps_e), .pwm_out(pwm_e)
    );

    pwm_dac #(
        .CHANNELS(1), .DUTY_W(8), .CNT_W(4), .PERIOD(8), .CENTER_ALIGNED(1)
    ) u_ctr (
        .clk(clk), .resetn(resetn), .enable(en_c), .duty(duty_c),
        .duty_valid(vld_c), .duty_ready(rdy_c), .period_start(ps_c), .pwm_out(pwm_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic to_phase(input int p);
        for (int i = 0; i < 16 && (k % 16) != p; i++) step();
    endtask

    // Counts highs over the current sample plus the next 15.
    task automatic count_window(output int h0, output int h1, output int ps);
        h0 = 0;
        h1 = 0;
        ps = 0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) step();
            h0 += int'(pwm_e[0]);
            h1 += int'(pwm_e[1]);
            ps += int'(ps_e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int h0, h1, ps;
        logic [15:0] cap, cap_ps;

        resetn = 1'b0;
        en_e = 1'b0; vld_e = 1'b0; duty_e = '0;
        en_c = 1'b0; vld_c = 1'b0; duty_c = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pwm", 32'(pwm_e), 0);
        check("rst_ps",  32'(ps_e), 0);
        check("rst_rdy", 32'(rdy_e), 1);

        resetn = 1'b1;
        step();

        // Edge basic
        duty_e = {8'd12, 8'd4};
        vld_e  = 1'b1;
        step();
        vld_e  = 1'b0;
        check("pre_en_rdy", 32'(rdy_e), 0);
        en_e = 1'b1;
        k    = 0;
        step();
        check("first_ps",  32'(ps_e), 1);
        check("first_pwm", 32'(pwm_e), 3);
        check("first_rdy", 32'(rdy_e), 1);
        count_window(h0, h1, ps);
        check("edge_h0", h0, 4);
        check("edge_h1", h1, 12);
        check("edge_ps", ps, 1);
        step();
        count_window(h0, h1, ps);
        check("edge2_h0", h0, 4);
        check("edge2_h1", h1, 12);
        check("edge2_ps", ps, 1);

        // Double buffer
        to_phase(5);
        duty_e = {8'd12, 8'd8};
        vld_e  = 1'b1;
        step();
        check("db_rdy_drop", 32'(rdy_e), 0);
        duty_e = {8'd12, 8'd2};
        to_phase(15);
        check("db_hold", 32'(rdy_e), 0);
        step();
        check("db_rdy_rise", 32'(rdy_e), 1);
        step();
        check("db_accept2", 32'(rdy_e), 0);
        vld_e = 1'b0;
        count_window(h0, h1, ps);
        check("db_h0_8", h0, 8);
        check("db_h1", h1, 12);
        check("db_rdy_after2", 32'(rdy_e), 1);
        step();
        count_window(h0, h1, ps);
        check("db_h0_2", h0, 2);

        // Boundary collision
        to_phase(15);
        duty_e = {8'd12, 8'd6};
        vld_e  = 1'b1;
        step();
        vld_e  = 1'b0;
        check("col_rdy", 32'(rdy_e), 0);
        step();
        count_window(h0, h1, ps);
        check("col_old", h0, 2);
        step();
        count_window(h0, h1, ps);
        check("col_new", h0, 6);

        // Saturation
        duty_e = {8'd255, 8'd0};
        vld_e  = 1'b1;
        step();
        vld_e  = 1'b0;
        to_phase(0);
        step();
        count_window(h0, h1, ps);
        check("sat_zero", h0, 0);
        check("sat_full", h1, 16);

        // Enable drop mid-period
        to_phase(7);
        check("pre_dis_pwm", 32'(pwm_e), 2);
        en_e = 1'b0;
        step();
        check("dis_pwm", 32'(pwm_e), 0);
        check("dis_ps",  32'(ps_e), 0);
        duty_e = {8'd255, 8'd5};
        vld_e  = 1'b1;
        step();
        vld_e  = 1'b0;
        check("dis_pwm2",   32'(pwm_e), 0);
        check("dis_accept", 32'(rdy_e), 0);
        en_e = 1'b1;
        k    = 0;
        step();
        check("reen_ps",  32'(ps_e), 1);
        check("reen_pwm", 32'(pwm_e), 3);
        check("reen_rdy", 32'(rdy_e), 1);
        count_window(h0, h1, ps);
        check("reen_h0", h0, 5);
        check("reen_h1", h1, 16);
        check("reen_ps_cnt", ps, 1);

        // Asynchronous reset mid-period
        to_phase(5);
        duty_e = {8'd255, 8'd9};
        vld_e  = 1'b1;
        step();
        vld_e  = 1'b0;
        check("prerst_rdy", 32'(rdy_e), 0);
        check("prerst_pwm1", 32'(pwm_e[1]), 1);
        resetn = 1'b0;
        #1;
        check("arst_pwm", 32'(pwm_e), 0);
        check("arst_rdy", 32'(rdy_e), 1);
        check("arst_ps",  32'(ps_e), 0);
        en_e = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        step();

        // Center mode, duty 3 of PERIOD 8
        duty_c = 8'd3;
        vld_c  = 1'b1;
        step();
        vld_c  = 1'b0;
        check("ctr_rdy_low", 32'(rdy_c), 0);
        en_c = 1'b1;
        k    = 0;
        for (int p = 0; p < 2; p++) begin
            cap    = '0;
            cap_ps = '0;
            for (int i = 0; i < 16; i++) begin
                step();
                cap[i]    = pwm_c[0];
                cap_ps[i] = ps_c;
            end
            check("ctr_pwm", 32'(cap), 32'h0000_E007);
            check("ctr_ps",  32'(cap_ps), 32'h0000_0001);
        end
        check("ctr_rdy", 32'(rdy_c), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
